regfile_write_scoreboard: RTL and testbench
===========================================

# regfile_write_scoreboard

Parametrised write-side control for the pipelined processor's register file. It decodes the writeback destination into one-hot wordlines for a register file of any power-of-two depth, and it tracks in-flight writes per register with saturating counters. Decode drives the RF write enables; the scoreboard drives the decode-stage hazard stall and issue back-pressure, with pipeline-flush support.

## Interface
Parameters:
- ADDR_W, 3: register index width; NUM_REGS = 2**ADDR_W.
- CNT_W, 2: per-register pending-write counter width; max in-flight writes per register = 2**CNT_W - 1.
- ZERO_REG_RO, 1: when 1, register 0 is hard-wired; it never gets a wordline and is never counted.

Ports:
- clk, input, 1: the block's single clock; all state updates on its rising edge.
- rst_n, input, 1: reset; asynchronous, active-low.
- issue_valid, input, 1: decode stage issues an instruction this cycle.
- issue_wr, input, 1: the issued instruction writes a register.
- issue_rd, input, ADDR_W: destination of the issued instruction.
- issue_ready, output, 1: issue accepted this cycle.
- src1_id, input, ADDR_W: source operand 1 index.
- src2_id, input, ADDR_W: source operand 2 index.
- src1_busy, output, 1: source 1 has pending writes.
- src2_busy, output, 1: source 2 has pending writes.
- wb_valid, input, 1: writeback stage is retiring an instruction.
- wb_wr, input, 1: the retiring instruction writes a register.
- wb_rd, input, ADDR_W: writeback destination.
- wordline, output, NUM_REGS: one-hot RF write enable.
- pending, output, NUM_REGS: bit i = counter i nonzero.
- flush, input, 1: pipeline flush; discard all pending state.
- err_underflow, output, 1: sticky; a writeback targeted a register whose counter was 0.

## Operation
- Decode: wordline = onehot(wb_rd) when wb_valid & wb_wr, else all zeros. Combinational, same cycle as wb. Bit 0 is forced 0 when ZERO_REG_RO = 1.
- Issue acceptance: acc = issue_valid & issue_ready.
- issue_ready = 0 only when issue_wr = 1, the target is counted, and cnt[issue_rd] is saturated. Otherwise 1, independent of issue_valid.
- inc_i = acc & issue_wr & (issue_rd == i).
- dec_i = wb_valid & wb_wr & (wb_rd == i).
- Neither inc nor dec applies to reg 0 when ZERO_REG_RO = 1.
- Counter next state:
  - inc & dec: unchanged.
  - inc only: +1.
  - dec only: -1 if nonzero. If zero, it stays 0 and err_underflow is set.
- flush: all counters go to 0 next edge. Flush overrides any same-cycle inc or dec. A same-cycle underflow still sets err_underflow.
- src*_busy = pending[src*_id], taken from registered counters only. A same-cycle writeback does not clear busy; the bypass network covers that case. With ZERO_REG_RO = 1, a source of 0 is never busy.
- err_underflow clears only on reset.

## Timing
- Reset (async assert) drives all counters, pending and err_underflow to 0. It also gives issue_ready = 1, src*_busy = 0, and wordline = 0 while wb_valid is low.
- Reset deassertion is synchronised externally; the first edge after release performs normal updates.
- Latencies:
  - wordline: 0 cycles from wb inputs.
  - pending and busy: 1 cycle after the issue/wb edge.
  - issue_ready: 0 cycles from issue inputs and current counters.
- Saturation: at cnt = 2**CNT_W - 1, issue_ready stays low until a writeback to that register has taken effect at an edge.
- Reset mid-operation discards all counts immediately, asynchronously.

## Structure
- Shared package rf_pkg holds:
  - default ADDR_W and CNT_W
  - localparam NUM_REGS
  - function onehot_dec(idx, en)
- One sub-module, wordline_decoder (ADDR_W, ZERO_REG_RO): a parametrised combinational generalisation of the 3-to-8 write decoder. It is instantiated once for the writeback port and reused for the inc vector on the issue port.
- The counter array is a generate loop inside regfile_write_scoreboard.

## Test plan
- Reset, then wb_valid = 1, wb_wr = 1, wb_rd = 5 (ADDR_W = 3) -> wordline = 8'h20 in the same cycle; err_underflow = 1 after the edge; pending stays 8'h00.
- Issue rd = 3, then rd = 3 again on the next cycle -> pending[3] = 1 and, with src1_id = 3, src1_busy = 1. Two writebacks to 3 are needed before pending[3] = 0; it is still 1 after the first.
- CNT_W = 2: issue rd = 2 three times -> issue_ready = 0 with issue_rd = 2; issue_rd = 4 still ready. One wb to 2 -> issue_ready = 1 next cycle.
- Same-cycle issue rd = 6 and wb rd = 6, with cnt[6] = 1 -> cnt[6] stays 1, no error. Repeating with cnt[6] = 0 gives cnt = 0 and no error.
- ZERO_REG_RO = 1: issue rd = 0 and wb rd = 0 -> wordline = 0, pending[0] = 0, src busy with id 0 = 0, no underflow.
- Load counts on regs 1, 4, 7, then assert flush together with an issue to rd = 1 -> pending = 0 next cycle. A later async rst_n pulse mid-stream clears err_underflow immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-side control.
//   DEF_ADDR_W / DEF_CNT_W : default register-index and pending-counter widths
//   NUM_REGS               : register count for the default index width
//   MAX_ADDR_W / MAX_REGS  : widest index the one-hot helper supports
//   onehot_dec(idx, en)    : one-hot decode of idx, all zeros when en is low
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_CNT_W  = 2;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  // The helper decodes at a fixed maximum width; callers zero-extend the
  // index going in and truncate the result to their own register count.
  localparam int MAX_ADDR_W = 6;
  localparam int MAX_REGS   = 2 ** MAX_ADDR_W;

  function automatic logic [MAX_REGS-1:0] onehot_dec(
    input logic [MAX_ADDR_W-1:0] idx,
    input logic                  en
  );
    logic [MAX_REGS-1:0] res;
    res = '0;
    if (en) res[idx] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/regfile_write_scoreboard_wordline_decoder.sv
// -----------------------------------------------------------------------------
// wordline_decoder
// Combinational one-hot decoder: the parametrised form of the register file's
// 3-to-8 write decoder. Register 0 never gets a wordline when it is hard-wired.
// Ports:
//   idx      [ADDR_W-1:0]   : register index to decode
//   en                      : decode enable; all outputs low when 0
//   wordline [2**ADDR_W-1:0]: one-hot select (or all zeros)
// ADDR_W must not exceed rf_pkg::MAX_ADDR_W.
// -----------------------------------------------------------------------------
module wordline_decoder
  import rf_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic [ADDR_W-1:0]    idx,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] wordline
);

  localparam int NREGS = 2 ** ADDR_W;

  // NOTE: every variable assigned in always_comb gets a full default first,
  // so no path can leave it holding a value and infer a latch.
  always_comb begin
    wordline = NREGS'(onehot_dec(MAX_ADDR_W'(idx), en));
    if (ZERO_REG_RO) wordline[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_write_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_write_scoreboard
// Write-side control for the register file. Decodes the writeback destination
// into one-hot write enables and keeps a saturating in-flight-write counter per
// register, which drives decode hazard detection and issue back-pressure.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   issue_valid/wr/rd         : decode-stage issue request and destination
//   issue_ready               : issue accepted this cycle (combinational)
//   src1_id, src2_id          : source operand indices
//   src1_busy, src2_busy      : source has in-flight writes (registered state)
//   wb_valid/wr/rd            : writeback-stage retirement and destination
//   wordline [NUM_REGS-1:0]   : one-hot RF write enable (combinational)
//   pending  [NUM_REGS-1:0]   : per-register "counter nonzero"
//   flush                     : discard all in-flight counts at the next edge
//   err_underflow             : sticky; writeback to a register with no count
// -----------------------------------------------------------------------------
module regfile_write_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_wr,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic                 issue_ready,
  input  logic [ADDR_W-1:0]    src1_id,
  input  logic [ADDR_W-1:0]    src2_id,
  output logic                 src1_busy,
  output logic                 src2_busy,
  input  logic                 wb_valid,
  input  logic                 wb_wr,
  input  logic [ADDR_W-1:0]    wb_rd,
  output logic [2**ADDR_W-1:0] wordline,
  output logic [2**ADDR_W-1:0] pending,
  input  logic                 flush,
  output logic                 err_underflow
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] incVec;
  logic [NREGS-1:0] decVec;
  logic [NREGS-1:0] pendingVec;
  logic [NREGS-1:0] satVec;
  logic [NREGS-1:0] underflowVec;
  logic             issueAcc;

  // Writeback decode: drives the RF write enables and doubles as the
  // per-register decrement vector, so both always agree.
  wordline_decoder #(
    .ADDR_W      (ADDR_W),
    .ZERO_REG_RO (ZERO_REG_RO)
  ) u_wbDecoder (
    .idx      (wb_rd),
    .en       (wb_valid & wb_wr),
    .wordline (decVec)
  );

  assign wordline = decVec;

  // A write issue is refused only when its destination counter is saturated.
  // A hard-wired register 0 never saturates (its counter is tied to zero),
  // so it is always accepted.
  assign issue_ready = ~(issue_wr & satVec[issue_rd]);
  assign issueAcc    = issue_valid & issue_ready;

  // Same decoder reused on the issue port to form the increment vector.
  wordline_decoder #(
    .ADDR_W      (ADDR_W),
    .ZERO_REG_RO (ZERO_REG_RO)
  ) u_issueDecoder (
    .idx      (issue_rd),
    .en       (issueAcc & issue_wr),
    .wordline (incVec)
  );

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    if (ZERO_REG_RO && gi == 0) begin : g_zero
      // Hard-wired register: never tracked, never busy, never underflows.
      assign pendingVec[gi]   = 1'b0;
      assign satVec[gi]       = 1'b0;
      assign underflowVec[gi] = 1'b0;
    end else begin : g_track
      logic [CNT_W-1:0] cntQ;

      // NOTE: sequential state is updated with non-blocking assignments so
      // every counter samples the pre-edge values of its neighbours' inputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cntQ <= '0;
        end else if (flush) begin
          cntQ <= '0;
        end else begin
          unique case ({incVec[gi], decVec[gi]})
            2'b10:   cntQ <= cntQ + CNT_W'(1);
            2'b01:   if (cntQ != '0) cntQ <= cntQ - CNT_W'(1);
            default: cntQ <= cntQ;  // idle, or issue and retire cancel out
          endcase
        end
      end

      assign pendingVec[gi]   = (cntQ != '0);
      assign satVec[gi]       = &cntQ;
      // A retire that coincides with a new issue to the same register is
      // balanced, so it is not an underflow even when the count is zero.
      assign underflowVec[gi] = decVec[gi] & ~incVec[gi] & (cntQ == '0);
    end
  end

  // Underflow is recorded even during a flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (|underflowVec) begin
      err_underflow <= 1'b1;
    end
  end

  assign pending = pendingVec;

  // Busy reflects registered counts only; a same-cycle writeback is covered
  // by the operand bypass network, not by clearing busy early.
  assign src1_busy = pendingVec[src1_id];
  assign src2_busy = pendingVec[src2_id];

endmodule

// File: tb/tb_regfile_write_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_scoreboard
// Directed bench for regfile_write_scoreboard at the default parameters
// (ADDR_W = 3, CNT_W = 2, ZERO_REG_RO = 1). Inputs change on the falling
// edge; combinational outputs are checked before the rising edge and
// registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_regfile_write_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic       issue_wr;
  logic [2:0] issue_rd;
  logic       issue_ready;
  logic [2:0] src1_id;
  logic [2:0] src2_id;
  logic       src1_busy;
  logic       src2_busy;
  logic       wb_valid;
  logic       wb_wr;
  logic [2:0] wb_rd;
  logic [7:0] wordline;
  logic [7:0] pending;
  logic       flush;
  logic       err_underflow;

  int nTests = 0;
  int nFail  = 0;

  regfile_write_scoreboard #(
    .ADDR_W      (3),
    .CNT_W       (2),
    .ZERO_REG_RO (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .src1_id       (src1_id),
    .src2_id       (src2_id),
    .src1_busy     (src1_busy),
    .src2_busy     (src2_busy),
    .wb_valid      (wb_valid),
    .wb_wr         (wb_wr),
    .wb_rd         (wb_rd),
    .wordline      (wordline),
    .pending       (pending),
    .flush         (flush),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    issue_rd    = 3'd0;
    wb_valid    = 1'b0;
    wb_wr       = 1'b0;
    wb_rd       = 3'd0;
    flush       = 1'b0;
  endtask

  task automatic setIssue(input logic [2:0] rd);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic setWb(input logic [2:0] rd);
    wb_valid = 1'b1;
    wb_wr    = 1'b1;
    wb_rd    = rd;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    src1_id = 3'd0;
    src2_id = 3'd0;
    rst_n   = 1'b0;
    #2;
    check("rst_ready",    issue_ready,              1);
    check("rst_pending",  pending,                  8'h00);
    check("rst_err",      err_underflow,            0);
    check("rst_wordline", wordline,                 8'h00);
    check("rst_busy",     {src1_busy, src2_busy},   2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Two issues to r3, then two writebacks needed to clear it.
    setIssue(3'd3);
    src1_id = 3'd3;
    #1;
    check("r3_ready",        issue_ready, 1);
    check("r3_busy_before",  src1_busy,   0);
    afterEdge();
    check("r3_pending_1",    pending,     8'h08);
    check("r3_busy_1",       src1_busy,   1);
    @(negedge clk);
    afterEdge();
    check("r3_pending_2",    pending,     8'h08);
    @(negedge clk);
    idle();
    setWb(3'd3);
    #1;
    check("r3_wordline",     wordline,    8'h08);
    check("r3_busy_same_wb", src1_busy,   1);
    afterEdge();
    check("r3_after_wb1",    pending,     8'h08);
    @(negedge clk);
    afterEdge();
    check("r3_after_wb2",    pending,     8'h00);
    check("r3_busy_clear",   src1_busy,   0);
    check("r3_no_err",       err_underflow, 0);

    // Saturate r2 at 3 in-flight writes.
    @(negedge clk);
    idle();
    setIssue(3'd2);
    afterEdge();
    @(negedge clk);
    afterEdge();
    @(negedge clk);
    afterEdge();
    check("r2_pending_sat",  pending,     8'h04);
    @(negedge clk);
    #1;
    check("r2_ready_sat",    issue_ready, 0);
    afterEdge();
    check("r2_blocked_hold", pending,     8'h04);
    check("r2_still_sat",    issue_ready, 0);
    @(negedge clk);
    issue_valid = 1'b0;
    issue_rd    = 3'd4;
    #1;
    check("r4_ready",        issue_ready, 1);
    issue_rd = 3'd2;
    #1;
    check("r2_ready_novalid", issue_ready, 0);
    issue_wr = 1'b0;
    #1;
    check("r2_ready_nowr",   issue_ready, 1);
    issue_wr = 1'b1;
    setWb(3'd2);
    #1;
    check("r2_ready_same_wb", issue_ready, 0);
    afterEdge();
    check("r2_ready_after_wb", issue_ready, 1);
    check("r2_pending_wb1",  pending,     8'h04);
    @(negedge clk);
    issue_wr = 1'b0;
    afterEdge();
    @(negedge clk);
    afterEdge();
    check("r2_drained",      pending,     8'h00);
    check("r2_no_err",       err_underflow, 0);

    // Same-cycle issue and writeback on r6.
    @(negedge clk);
    idle();
    setIssue(3'd6);
    src2_id = 3'd6;
    afterEdge();
    check("r6_pending_1",    pending,     8'h40);
    check("r6_busy",         src2_busy,   1);
    @(negedge clk);
    setWb(3'd6);
    afterEdge();
    check("r6_inc_dec_cnt1", pending,     8'h40);
    check("r6_inc_dec_err",  err_underflow, 0);
    @(negedge clk);
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    afterEdge();
    check("r6_drained",      pending,     8'h00);
    @(negedge clk);
    setIssue(3'd6);
    afterEdge();
    check("r6_inc_dec_cnt0", pending,     8'h00);
    check("r6_cnt0_err",     err_underflow, 0);
    check("r6_busy_clear",   src2_busy,   0);

    // Hard-wired register 0.
    @(negedge clk);
    idle();
    setIssue(3'd0);
    setWb(3'd0);
    src1_id = 3'd0;
    src2_id = 3'd0;
    #1;
    check("r0_wordline",     wordline,    8'h00);
    check("r0_ready",        issue_ready, 1);
    afterEdge();
    check("r0_pending",      pending,     8'h00);
    check("r0_busy",         {src1_busy, src2_busy}, 2'b00);
    check("r0_no_err",       err_underflow, 0);

    // Non-writing retirement produces no wordline and no underflow.
    @(negedge clk);
    idle();
    wb_valid = 1'b1;
    wb_rd    = 3'd5;
    #1;
    check("wb_nowr_wordline", wordline,   8'h00);
    afterEdge();
    check("wb_nowr_err",     err_underflow, 0);

    // Writeback to r5 with an empty counter.
    @(negedge clk);
    wb_wr = 1'b1;
    #1;
    check("r5_wordline",     wordline,    8'h20);
    afterEdge();
    check("r5_underflow",    err_underflow, 1);
    check("r5_pending",      pending,     8'h00);

    // Load r1, r4, r7 then flush alongside an issue to r1.
    @(negedge clk);
    idle();
    setIssue(3'd1);
    afterEdge();
    @(negedge clk);
    issue_rd = 3'd4;
    afterEdge();
    @(negedge clk);
    issue_rd = 3'd7;
    afterEdge();
    check("load_pending",    pending,     8'h92);
    @(negedge clk);
    issue_rd = 3'd1;
    flush    = 1'b1;
    afterEdge();
    check("flush_pending",   pending,     8'h00);
    check("flush_err_sticky", err_underflow, 1);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    flush    = 1'b0;
    issue_rd = 3'd7;
    src1_id  = 3'd7;
    afterEdge();
    check("r7_pending",      pending,     8'h80);
    check("r7_busy",         src1_busy,   1);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pending",    pending,     8'h00);
    check("arst_err",        err_underflow, 0);
    check("arst_busy",       src1_busy,   0);
    @(negedge clk);
    rst_n = 1'b1;
    afterEdge();
    check("post_rst_err",    err_underflow, 0);
    check("post_rst_ready",  issue_ready, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
